lcd_frame_scan: RTL and testbench

// Display-refresh stage directly downstream of LCD_CTRL. After LCD_CTRL pulses done, this block

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_skid_fifo.sv | 73 +++++++
 rtl/lcd_frame_scan.sv | 190 +++++++++++++++++++
 tb/tb_lcd_frame_scan.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lcd_pkg
// Brief   : Shared image geometry defaults, scan FSM encoding and marker bits.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package lcd_pkg;

    localparam int c_DEF_IMG_W   = 8;
    localparam int c_DEF_IMG_H   = 8;
    localparam int c_DEF_DW      = 8;
    localparam int c_DEF_AW      = 6;
    localparam int c_DEF_H_BLANK = 2;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Marker bits sit directly above the pixel in every FIFO entry.
    localparam int c_MRK_LINE_START  = 0;
    localparam int c_MRK_FRAME_START = 1;
    localparam int c_MRK_FRAME_END   = 2;
    localparam int c_MRK_W           = 3;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_skid_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lcd_skid_fifo
// Brief   : Two-entry FIFO holding pixel plus markers; push and pop may coincide.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_skid_fifo #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_cnt
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (cnt_q != 2'd0);
    assign w_push = i_push && ((cnt_q != 2'd2) || w_pop);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        case ({w_push, w_pop})
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    slot0_d = i_data;
                end else begin
                    slot1_d = i_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot0_d = i_data;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = i_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_head = slot0_q;
    assign o_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_scan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : lcd_frame_scan
// Brief   : Reads the processed image buffer row by row and streams it to the
//           panel driver with line/frame markers and a horizontal blank.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_frame_scan
    import lcd_pkg::*;
#(
    parameter int IMG_W   = c_DEF_IMG_W,
    parameter int IMG_H   = c_DEF_IMG_H,
    parameter int DW      = c_DEF_DW,
    parameter int AW      = c_DEF_AW,
    parameter int H_BLANK = c_DEF_H_BLANK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          MEM_EN,
    output logic [AW-1:0] MEM_A,
    input  logic [DW-1:0] MEM_Q,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          line_start,
    output logic          frame_start,
    output logic          frame_end,
    output logic          busy,
    output logic          scan_done
);

    localparam int c_NPIX  = IMG_W * IMG_H;
    localparam int c_RA_W  = AW + 1;
    localparam int c_COL_W = clog2_min1(IMG_W);
    localparam int c_ROW_W = clog2_min1(IMG_H);
    localparam int c_BLK_W = clog2_min1(H_BLANK);
    localparam int c_EW    = DW + c_MRK_W;

    localparam logic [c_RA_W-1:0]  c_NPIX_RA  = c_RA_W'(c_NPIX);
    localparam logic [c_RA_W-1:0]  c_LAST_RA  = c_RA_W'(c_NPIX - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(IMG_H - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic               c_HAS_GAP  = (H_BLANK > 0);

    logic [1:0]         state_q, state_d;
    logic [c_RA_W-1:0]  rd_addr_q, rd_addr_d;
    logic [c_COL_W-1:0] rd_col_q, rd_col_d;
    logic               inflight_q, inflight_d;
    logic [c_MRK_W-1:0] infl_mrk_q, infl_mrk_d;
    logic [c_COL_W-1:0] col_q, col_d;
    logic [c_ROW_W-1:0] row_q, row_d;
    logic [c_BLK_W-1:0] blank_q, blank_d;

    logic [c_EW-1:0]    w_head;
    logic [1:0]         w_cnt;
    logic               w_run;
    logic               w_pop;
    logic [2:0]         w_level;
    logic               w_issue;
    logic               w_row_end;
    logic               w_frame_last;
    logic [c_MRK_W-1:0] w_issue_mrk;

    lcd_skid_fifo #(
        .WIDTH (c_EW)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (inflight_q),
        .i_data ({infl_mrk_q, MEM_Q}),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_cnt  (w_cnt)
    );

    assign w_run     = (state_q == c_ST_RUN);
    assign pix_valid = w_run && (w_cnt != 2'd0);
    assign w_pop     = pix_valid && pix_ready;

    // Occupancy after this cycle's pop; the in-flight read always lands in a free slot.
    assign w_level = {1'b0, w_cnt} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_issue = (w_run || (state_q == c_ST_GAP))
                  && (rd_addr_q < c_NPIX_RA)
                  && (w_level < 3'd2);

    assign MEM_EN = ~w_issue;
    assign MEM_A  = rd_addr_q[AW-1:0];

    always_comb begin
        w_issue_mrk                    = '0;
        w_issue_mrk[c_MRK_LINE_START]  = (rd_col_q == '0);
        w_issue_mrk[c_MRK_FRAME_START] = (rd_addr_q == '0);
        w_issue_mrk[c_MRK_FRAME_END]   = (rd_addr_q == c_LAST_RA);
    end

    assign w_row_end    = w_pop && (col_q == c_LAST_COL);
    assign w_frame_last = w_row_end && (row_q == c_LAST_ROW);

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_col_d   = rd_col_q;
        col_d      = col_q;
        row_d      = row_q;
        blank_d    = blank_q;
        inflight_d = w_issue;
        infl_mrk_d = w_issue ? w_issue_mrk : infl_mrk_q;

        if (w_issue) begin
            rd_addr_d = rd_addr_q + c_RA_W'(1);
            rd_col_d  = (rd_col_q == c_LAST_COL) ? '0 : rd_col_q + c_COL_W'(1);
        end
        if (w_pop) begin
            col_d = (col_q == c_LAST_COL) ? '0 : col_q + c_COL_W'(1);
            if (w_row_end && !w_frame_last) begin
                row_d = row_q + c_ROW_W'(1);
            end
        end

        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    state_d   = c_ST_RUN;
                    rd_addr_d = '0;
                    rd_col_d  = '0;
                    col_d     = '0;
                    row_d     = '0;
                end
            end
            c_ST_RUN: begin
                if (w_frame_last) begin
                    state_d = c_ST_DONE;
                end else if (w_row_end && c_HAS_GAP) begin
                    state_d = c_ST_GAP;
                    blank_d = '0;
                end
            end
            c_ST_GAP: begin
                if (blank_q == c_BLK_LAST) begin
                    state_d = c_ST_RUN;
                end else begin
                    blank_d = blank_q + c_BLK_W'(1);
                end
            end
            c_ST_DONE: begin
                // Park the address at 0 so MEM_A idles cleanly between frames.
                state_d   = c_ST_IDLE;
                rd_addr_d = '0;
                rd_col_d  = '0;
                col_d     = '0;
                row_d     = '0;
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= c_ST_IDLE;
            rd_addr_q  <= '0;
            rd_col_q   <= '0;
            inflight_q <= 1'b0;
            infl_mrk_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            blank_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_col_q   <= rd_col_d;
            inflight_q <= inflight_d;
            infl_mrk_q <= infl_mrk_d;
            col_q      <= col_d;
            row_q      <= row_d;
            blank_q    <= blank_d;
        end
    end

    assign pix_data    = pix_valid ? w_head[DW-1:0] : '0;
    assign line_start  = pix_valid && w_head[DW + c_MRK_LINE_START];
    assign frame_start = pix_valid && w_head[DW + c_MRK_FRAME_START];
    assign frame_end   = pix_valid && w_head[DW + c_MRK_FRAME_END];

    assign busy      = w_run || (state_q == c_ST_GAP);
    assign scan_done = (state_q == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_scan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_lcd_frame_scan
// Brief   : Directed self-checking bench for lcd_frame_scan with a buffer model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lcd_frame_scan;

    localparam int c_W    = 8;
    localparam int c_H    = 8;
    localparam int c_NPIX = c_W * c_H;
    localparam int c_HB   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       MEM_EN;
    logic [5:0] MEM_A;
    logic [7:0] MEM_Q;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       line_start;
    logic       frame_start;
    logic       frame_end;
    logic       busy;
    logic       scan_done;

    logic [7:0] mem [c_NPIX];
    logic [7:0] mem_q = 8'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (MEM_EN === 1'b0) mem_q <= mem[MEM_A];
    end
    assign MEM_Q = mem_q;

    lcd_frame_scan #(
        .IMG_W   (c_W),
        .IMG_H   (c_H),
        .DW      (8),
        .AW      (6),
        .H_BLANK (c_HB)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .MEM_EN      (MEM_EN),
        .MEM_A       (MEM_A),
        .MEM_Q       (MEM_Q),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy),
        .scan_done   (scan_done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All outputs packed MSB-first; only MEM_EN (bit 20) is 1 in reset.
    task automatic check_reset_outputs(input string tag);
        check(tag, int'({MEM_EN, MEM_A, pix_valid, pix_data, line_start,
                         frame_start, frame_end, busy, scan_done}), 32'h0010_0000);
    endtask

    // ready_mode: 0 always ready, 1 random, 2 held low for cycles 0..19.
    task automatic run_frame(input int ready_mode, input bit inj_start,
                             input int abort_px, input bit timed);
        int issued = 0;
        int xfer   = 0;
        int outst  = 0;
        int fe_i   = -10;
        bit pop;
        bit finished = 1'b0;

        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 600 && !finished; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            start = inj_start && (i == 10 || i == 40);
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = (i >= 20);
            endcase
            @(negedge clk);
            pop   = pix_valid && pix_ready;
            outst = issued - xfer;
            if (i == 0) check("busy_rise", int'(busy), 1);

            if (abort_px >= 0 && pix_valid && xfer == abort_px) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort_reset");
                finished = 1'b1;
            end else begin
                if (!MEM_EN) begin
                    check("rd_addr", int'(MEM_A), issued);
                    check("rd_level", int'((outst - int'(pop)) < 2), 1);
                    if (timed && issued == 0) check("rd_latency", i, 0);
                end
                if (ready_mode == 2 && i == 19) begin
                    check("hold_reads", issued, 2);
                    check("hold_en", int'(MEM_EN), 1);
                end
                if (pix_valid) begin
                    check("pix_data", int'(pix_data), xfer);
                    check("line_start", int'(line_start), int'((xfer % c_W) == 0));
                    check("frame_start", int'(frame_start), int'(xfer == 0));
                    check("frame_end", int'(frame_end), int'(xfer == c_NPIX - 1));
                    if (pop && timed)
                        check("pix_time", i, 2 + (xfer / c_W) * (c_W + c_HB) + (xfer % c_W));
                    if (pop && frame_end) fe_i = i;
                end
                if (scan_done) begin
                    check("done_all_xfer", xfer, c_NPIX);
                    check("done_busy", int'(busy), 0);
                    check("done_after_fe", i - fe_i, 1);
                    if (timed) check("done_time", i, 2 + c_NPIX + (c_H - 1) * c_HB);
                    finished = 1'b1;
                end
                if (!MEM_EN) issued++;
                if (pop) xfer++;
            end
        end
        start = 1'b0;
        check("frame_end_reached", int'(finished), 1);
        if (abort_px < 0) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("done_one_cycle", int'(scan_done), 0);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        for (int k = 0; k < c_NPIX; k++) mem[k] = 8'(k);
        rst_n     = 1'b1;
        start     = 1'b0;
        pix_ready = 1'b0;
        #2 rst_n  = 1'b0;

        // Reset held with random inputs, then released with start low
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            start     = 1'($urandom_range(0, 1));
            pix_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_reset_outputs("reset_hold");
        end
        @(posedge clk); #1;
        start     = 1'b0;
        pix_ready = 1'b1;
        rst_n     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("release_mem_en", int'(MEM_EN), 1);
            @(posedge clk); #1;
        end

        // Full-rate frame with exact timing
        run_frame(0, 1'b0, -1, 1'b1);
        // Random backpressure
        run_frame(1, 1'b0, -1, 1'b0);
        // Start pulses during an active frame are ignored
        run_frame(0, 1'b1, -1, 1'b1);
        // Backpressure for 20 cycles after start
        run_frame(2, 1'b0, -1, 1'b0);
        // Abort with reset while pixel 30 is pending
        run_frame(0, 1'b0, 30, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_reset_outputs("abort_hold");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_release_en", int'(MEM_EN), 1);
        // Fresh full frame after the abort
        run_frame(0, 1'b0, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
